// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: branch op codes,
// FSM state encoding, default widths and the redirect-op classifier.
package pc_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int OFF_W_DEF  = 12;

    // Op of the resolving instruction, identical to the tester_flags encoding.
    typedef enum logic [2:0] {
        OP_JF   = 3'b000,
        OP_JT   = 3'b001,
        OP_J    = 3'b010,
        OP_JAL  = 3'b011,
        OP_JR   = 3'b100,
        OP_NONE = 3'b111
    } op_tf_e;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        ST_BOOT     = 2'b00,
        ST_FETCH    = 2'b01,
        ST_REDIRECT = 2'b10
    } pc_state_t;

    // True for the ops that are allowed to redirect the PC; 101/110/111 never do.
    function automatic logic is_redirect_op(input logic [2:0] op);
        logic ok;
        case (op)
            OP_JF, OP_JT, OP_J, OP_JAL, OP_JR: ok = 1'b1;
            default:                           ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/pc_target_mux.sv
// Combinational branch/jump target select. Relative ops add the sign-extended
// offset to the branch PC; absolute ops pass their target through. All
// arithmetic wraps modulo 2^ADDR_W.
module pc_target_mux
    import pc_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int OFF_W  = OFF_W_DEF
) (
    input  logic [2:0]        op_i,
    input  logic [ADDR_W-1:0] br_pc_i,
    input  logic [OFF_W-1:0]  offset_i,
    input  logic [ADDR_W-1:0] target_i,
    input  logic [ADDR_W-1:0] reg_target_i,
    output logic [ADDR_W-1:0] target_o,
    output logic              op_ok_o
);

    logic [ADDR_W-1:0] offset_ext_s;

    // Sign-extend the offset and pick the target for the resolving op.
    always_comb begin
        offset_ext_s = {{(ADDR_W-OFF_W){offset_i[OFF_W-1]}}, offset_i};
        op_ok_o      = is_redirect_op(op_i);
        target_o     = {ADDR_W{1'b0}};
        case (op_i)
            OP_JF, OP_JT: target_o = br_pc_i + offset_ext_s;
            OP_J, OP_JAL: target_o = target_i;
            OP_JR:        target_o = reg_target_i;
            default:      target_o = {ADDR_W{1'b0}};
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch program-counter sequencer. Advances the PC under the instruction
// memory handshake, redirects on a taken branch/jump with a one-cycle flush
// bubble, and issues the jal link write-back. All outputs are registered.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                OFF_W    = OFF_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              tf_out,
    input  logic [2:0]        OP_TF,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [OFF_W-1:0]  offset,
    input  logic [ADDR_W-1:0] target,
    input  logic [ADDR_W-1:0] reg_target,
    input  logic              stall,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              pc_valid,
    output logic              flush,
    output logic              link_we,
    output logic [ADDR_W-1:0] link_data
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    pc_state_t         state_q;
    logic [ADDR_W-1:0] pc_q;
    logic              pc_valid_q;
    logic              flush_q;
    logic              link_we_q;
    logic [ADDR_W-1:0] link_data_q;

    logic [ADDR_W-1:0] redirect_pc_d;
    logic [ADDR_W-1:0] seq_pc_d;
    logic [ADDR_W-1:0] link_data_d;
    logic              op_ok_s;
    logic              redirect_s;
    logic              advance_s;

    pc_target_mux #(
        .ADDR_W (ADDR_W),
        .OFF_W  (OFF_W)
    ) u_target_mux (
        .op_i         (OP_TF),
        .br_pc_i      (br_pc),
        .offset_i     (offset),
        .target_i     (target),
        .reg_target_i (reg_target),
        .target_o     (redirect_pc_d),
        .op_ok_o      (op_ok_s)
    );

    // Decision terms; only consumed in FETCH, so a br_valid during REDIRECT is ignored.
    always_comb begin
        redirect_s  = br_valid && !tf_out && op_ok_s;
        advance_s   = imem_ready && !stall;
        seq_pc_d    = pc_q + ADDR_ONE;
        link_data_d = br_pc + ADDR_ONE;
    end

    // Sequencer FSM with registered PC and strobes; reset > redirect > stall > advance.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q     <= ST_BOOT;
            pc_q        <= RESET_PC;
            pc_valid_q  <= 1'b0;
            flush_q     <= 1'b0;
            link_we_q   <= 1'b0;
            link_data_q <= {ADDR_W{1'b0}};
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_q    <= ST_FETCH;
                    pc_valid_q <= 1'b1;
                    flush_q    <= 1'b0;
                    link_we_q  <= 1'b0;
                end
                ST_FETCH: begin
                    if (redirect_s) begin
                        state_q    <= ST_REDIRECT;
                        pc_q       <= redirect_pc_d;
                        pc_valid_q <= 1'b0;
                        flush_q    <= 1'b1;
                        if (OP_TF == OP_JAL) begin
                            link_we_q   <= 1'b1;
                            link_data_q <= link_data_d;
                        end else begin
                            link_we_q   <= 1'b0;
                        end
                    end else begin
                        state_q    <= ST_FETCH;
                        pc_valid_q <= 1'b1;
                        flush_q    <= 1'b0;
                        link_we_q  <= 1'b0;
                        if (advance_s) begin
                            pc_q <= seq_pc_d;
                        end else begin
                            pc_q <= pc_q;
                        end
                    end
                end
                ST_REDIRECT: begin
                    state_q    <= ST_FETCH;
                    pc_valid_q <= 1'b1;
                    flush_q    <= 1'b0;
                    link_we_q  <= 1'b0;
                end
                default: begin
                    state_q    <= ST_BOOT;
                    pc_q       <= RESET_PC;
                    pc_valid_q <= 1'b0;
                    flush_q    <= 1'b0;
                    link_we_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pc        = pc_q;
    assign pc_valid  = pc_valid_q;
    assign flush     = flush_q;
    assign link_we   = link_we_q;
    assign link_data = link_data_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer. Inputs are driven and
// outputs sampled on the falling edge, away from the active rising edge.
module tb_pc_sequencer;

    localparam int          ADDR_W   = 16;
    localparam int          OFF_W    = 12;
    localparam logic [15:0] RESET_PC = 16'h0010;

    logic              CLK;
    logic              RESET;
    logic              tf_out;
    logic [2:0]        OP_TF;
    logic              br_valid;
    logic [ADDR_W-1:0] br_pc;
    logic [OFF_W-1:0]  offset;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] reg_target;
    logic              stall;
    logic              imem_ready;
    logic [ADDR_W-1:0] pc;
    logic              pc_valid;
    logic              flush;
    logic              link_we;
    logic [ADDR_W-1:0] link_data;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(
        .ADDR_W   (ADDR_W),
        .OFF_W    (OFF_W),
        .RESET_PC (RESET_PC)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .tf_out     (tf_out),
        .OP_TF      (OP_TF),
        .br_valid   (br_valid),
        .br_pc      (br_pc),
        .offset     (offset),
        .target     (target),
        .reg_target (reg_target),
        .stall      (stall),
        .imem_ready (imem_ready),
        .pc         (pc),
        .pc_valid   (pc_valid),
        .flush      (flush),
        .link_we    (link_we),
        .link_data  (link_data)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare all five outputs against expected values.
    task automatic chk_all(input string tag, input logic [15:0] e_pc, input logic e_v,
                           input logic e_fl, input logic e_we, input logic [15:0] e_ld);
        chk({tag, ".pc"},        pc,               e_pc);
        chk({tag, ".pc_valid"},  {15'd0, pc_valid}, {15'd0, e_v});
        chk({tag, ".flush"},     {15'd0, flush},    {15'd0, e_fl});
        chk({tag, ".link_we"},   {15'd0, link_we},  {15'd0, e_we});
        chk({tag, ".link_data"}, link_data,         e_ld);
    endtask

    initial begin
        RESET = 1'b0; tf_out = 1'b1; OP_TF = 3'b111; br_valid = 1'b0;
        br_pc = 16'h0000; offset = 12'h000; target = 16'h0000; reg_target = 16'h0000;
        stall = 1'b0; imem_ready = 1'b0;

        // Reset held for two cycles.
        step(); step();
        chk_all("reset", 16'h0010, 1'b0, 1'b0, 1'b0, 16'h0000);

        // Release: BOOT cycle, then valid fetch at RESET_PC.
        RESET = 1'b1; imem_ready = 1'b1;
        step();
        chk_all("boot", 16'h0010, 1'b1, 1'b0, 1'b0, 16'h0000);

        // Sequential advance.
        step(); chk("seq1", pc, 16'h0011);
        step(); chk("seq2", pc, 16'h0012);
        step(); chk("seq3", pc, 16'h0013);

        // Stall holds.
        stall = 1'b1;
        step(); chk("stall_hold", pc, 16'h0013);
        imem_ready = 1'b0; stall = 1'b0;
        step(); chk("ready_low_hold", pc, 16'h0013);
        imem_ready = 1'b1;

        // jt taken: 0x20 + (-4) = 0x1C.
        br_valid = 1'b1; OP_TF = 3'b001; br_pc = 16'h0020; offset = 12'hFFC; tf_out = 1'b0;
        step();
        chk_all("jt_redirect", 16'h001C, 1'b0, 1'b1, 1'b0, 16'h0000);
        // br_valid still high during REDIRECT: must be ignored.
        step();
        chk_all("jt_fetch", 16'h001C, 1'b1, 1'b0, 1'b0, 16'h0000);

        // jt not taken: normal advance.
        tf_out = 1'b1;
        step();
        chk_all("jt_not_taken", 16'h001D, 1'b1, 1'b0, 1'b0, 16'h0000);

        // jal: link write in REDIRECT.
        OP_TF = 3'b011; target = 16'h0100; br_pc = 16'h0042; tf_out = 1'b0;
        step();
        chk_all("jal_redirect", 16'h0100, 1'b0, 1'b1, 1'b1, 16'h0043);
        br_valid = 1'b0;
        step();
        chk_all("jal_fetch", 16'h0100, 1'b1, 1'b0, 1'b0, 16'h0043);

        // jr under stall and imem_ready low still redirects.
        br_valid = 1'b1; OP_TF = 3'b100; reg_target = 16'hFFFF; stall = 1'b1; imem_ready = 1'b0;
        step();
        chk_all("jr_redirect", 16'hFFFF, 1'b0, 1'b1, 1'b0, 16'h0043);
        br_valid = 1'b0;
        step();
        chk_all("jr_fetch", 16'hFFFF, 1'b1, 1'b0, 1'b0, 16'h0043);
        step();
        chk("jr_stall_hold", pc, 16'hFFFF);
        stall = 1'b0; imem_ready = 1'b1;
        step();
        chk("wrap", pc, 16'h0000);

        // Op 111 with tf_out=0 never redirects.
        br_valid = 1'b1; OP_TF = 3'b111; tf_out = 1'b0;
        step();
        chk_all("op_none", 16'h0001, 1'b1, 1'b0, 1'b0, 16'h0043);

        // jf taken with positive offset: 0x0030 + 5 = 0x0035.
        OP_TF = 3'b000; br_pc = 16'h0030; offset = 12'h005;
        step();
        chk_all("jf_redirect", 16'h0035, 1'b0, 1'b1, 1'b0, 16'h0043);
        br_valid = 1'b0;
        step();

        // Reset during a jal REDIRECT aborts it.
        br_valid = 1'b1; OP_TF = 3'b011; target = 16'h0200; br_pc = 16'h0050;
        step();
        chk_all("jal2_redirect", 16'h0200, 1'b0, 1'b1, 1'b1, 16'h0051);
        RESET = 1'b0; br_valid = 1'b0;
        step();
        chk_all("reset_mid_redirect", 16'h0010, 1'b0, 1'b0, 1'b0, 16'h0000);
        RESET = 1'b1;
        step();
        chk_all("reboot", 16'h0010, 1'b1, 1'b0, 1'b0, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer that sits directly downstream of `tester_flags` and consumes its `out` decision. It holds the fetch PC and advances it sequentially under a simple instruction-memory handshake. On a taken branch or jump it redirects the PC to the resolved target and emits a one-cycle pipeline flush. For `jal` it also issues the link write-back.

## Interface
- `ADDR_W`, 16: PC / address width.
- `OFF_W`, 12: width of the signed relative offset for `jf`/`jt`.
- `RESET_PC`, 0: PC value loaded on reset.

- `CLK` input 1: single clock, rising edge.
- `RESET` input 1: synchronous, active-low reset, sampled on `CLK` rising edge.
- `tf_out` input 1: `out` of `tester_flags`.
  - 0 = take the branch/jump.
  - 1 = fall through.
- `OP_TF` input 3: op of the resolving instruction, same encoding fed to `tester_flags`.
  - 000 `jf`, 001 `jt`, 010 `j`, 011 `jal`, 100 `jr`, 111 none.
- `br_valid` input 1: a branch/jump is resolving this cycle.
- `br_pc` input ADDR_W: address of the resolving instruction.
- `offset` input OFF_W: signed relative offset (`jf`/`jt`).
- `target` input ADDR_W: absolute target (`j`/`jal`).
- `reg_target` input ADDR_W: register value (`jr`).
- `stall` input 1: downstream hold; PC must not advance.
- `imem_ready` input 1: instruction memory accepted the current `pc`.
- `pc` output ADDR_W: fetch address.
- `pc_valid` output 1: `pc` is a valid fetch request.
- `flush` output 1: one-cycle pulse; kill younger in-flight instructions.
- `link_we` output 1: one-cycle write strobe for the `jal` return address.
- `link_data` output ADDR_W: return address, `br_pc + 1`.

## Operation
- **Redirect condition:** `br_valid && !tf_out && OP_TF ∈ {000,001,010,011,100}`. All other `OP_TF` codes never redirect, regardless of `tf_out`.
- **Target select:**
  - 000/001: `br_pc + sign_extend(offset)`.
  - 010/011: `target`.
  - 100: `reg_target`.
  - All PC arithmetic is modulo 2^ADDR_W; wrap-around is silent, no error.
- **FSM states:** BOOT, FETCH, REDIRECT.
- **BOOT:** entered on reset.
  - `pc = RESET_PC`; `pc_valid`, `flush`, `link_we` all 0.
  - Always goes to FETCH on the next cycle.
- **FETCH:** `pc_valid = 1`.
  - If the redirect condition holds, load the target into `pc` and go to REDIRECT.
  - Else if `imem_ready && !stall`, `pc <= pc + 1`.
  - Else hold `pc`.
- **REDIRECT:** lasts exactly one cycle, then FETCH.
  - `pc_valid = 0`, `flush = 1`.
  - `link_we = 1` iff the redirecting op was 011; `link_data` is registered `br_pc + 1` (wrapped).
  - A `br_valid` arriving in REDIRECT is ignored; it belongs to a flushed instruction.
- **Priority:** reset > redirect > stall > sequential advance. A redirect overrides `stall` and a low `imem_ready`.
- A not-taken branch (`tf_out = 1`) behaves exactly like a normal FETCH cycle.
- `link_data` holds its last value when `link_we = 0`; it is 0 after reset.

## Timing
- **Reset values:** `pc = RESET_PC`; `pc_valid = 0`, `flush = 0`, `link_we = 0`, `link_data = 0`.
- The first valid fetch appears 1 cycle after `RESET` is released (BOOT cycle).
- **Redirect latency:** condition sampled at edge N. During cycle N+1, `pc = target`, `pc_valid = 0`, `flush = 1`. From cycle N+2, `pc = target` with `pc_valid = 1`. Each taken branch costs one bubble.
- **Sequential latency:** `pc` increments on the edge where `pc_valid && imem_ready && !stall`.
- Reset asserted mid-REDIRECT aborts it: `flush` and `link_we` are 0 from the next cycle and the FSM goes to BOOT.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package `pc_pkg`:
  - `OP_TF` encodings: `OP_JF`, `OP_JT`, `OP_J`, `OP_JAL`, `OP_JR`, `OP_NONE`.
  - State typedef `pc_state_t`.
  - `ADDR_W` default.
- One natural sub-module, `pc_target_mux`: combinational target select and sign-extension. Everything else stays in `pc_sequencer`.

## Test plan
- **Reset release:** `RESET` low for 2 cycles, then high, `RESET_PC = 0x0010` -> `pc = 0x0010` with `pc_valid = 0` for one cycle, then `pc_valid = 1`.
- **Sequential and stall:** with `imem_ready = 1` and `stall = 0` for 3 cycles -> `pc` goes 0x10, 0x11, 0x12, 0x13. With `stall = 1` -> `pc` holds.
- **`jt` taken and not taken:** `OP_TF = 001`, `br_pc = 0x0020`, `offset = -4`.
  - `tf_out = 0` -> `flush` pulse; `pc = 0x001C`, valid the following cycle.
  - `tf_out = 1` -> no flush; `pc` advances to +1.
- **`jal`:** `OP_TF = 011`, `target = 0x0100`, `br_pc = 0x0042`, `tf_out = 0` -> in the REDIRECT cycle `link_we = 1` and `link_data = 0x0043`; then `pc = 0x0100`.
- **`jr` with stall and wrap:** `OP_TF = 100`, `reg_target = 0xFFFF`, `stall = 1` -> redirect still happens. The next sequential advance wraps `pc` to 0x0000.
- **Mid-operation events:**
  - `OP_TF = 111` with `tf_out = 0` -> no redirect.
  - `RESET` low during REDIRECT -> next cycle `flush = 0`, `link_we = 0`, `pc = RESET_PC`.
